// File: rtl/spi_peripheral.sv
// spi_peripheral: SPI mode-0 peripheral that writes a fixed map of five 8-bit
// control registers (0x00-0x04) from 16-bit frames {R/W, addr[6:0], data[7:0]}.
// Optional readback on cipo is built only when SPI_READBACK_EN is defined.
module spi_peripheral (
    input  logic       clk,
    input  logic       rst,
    input  logic       sclk,
    input  logic       copi,
    input  logic       ncs,
    output logic       cipo,
    output logic [7:0] en_reg_out_7_0,
    output logic [7:0] en_reg_out_15_8,
    output logic [7:0] en_reg_pwm_7_0,
    output logic [7:0] en_reg_pwm_15_8,
    output logic [7:0] pwm_duty_cycle,
    output logic       frame_err
);

    localparam int unsigned FRAME_W  = 16;
    localparam int unsigned CNT_W    = 5;
    localparam int unsigned DATA_W   = 8;
    localparam int unsigned ADDR_W   = 7;
    localparam int unsigned NUM_REGS = 5;

    localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_W + 1);
    localparam logic [ADDR_W-1:0] ADDR_MAX = ADDR_W'(NUM_REGS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    state_e state_q, state_d;

    // [0],[1] synchronize; [2] is the previous synchronized value for edges
    logic [2:0] sclk_sync_q;
    logic [2:0] copi_sync_q;
    logic [2:0] ncs_sync_q;

    logic [1:0]         settle_q;
    logic               armed_q;
    logic               pend_q;
    logic [FRAME_W-1:0] shift_q;
    logic [CNT_W-1:0]   cnt_q;
    logic [DATA_W-1:0]  regs_q [NUM_REGS];
    logic               frame_err_q;

    logic               sclk_rise_c;
    logic               ncs_fall_c;
    logic               ncs_rise_c;
    logic               start_c;
    logic               clear_c;
    logic               shift_en_c;
    logic               commit_c;
    logic               wr_en_c;
    logic               err_c;
    logic [ADDR_W-1:0]  addr_c;
    logic [FRAME_W-1:0] shift_nx_c;

    // Synchronizers; ncs idles high, sclk and copi idle low
    always_ff @(posedge clk) begin
        if (rst) begin
            sclk_sync_q <= 3'b000;
            copi_sync_q <= 3'b000;
            ncs_sync_q  <= 3'b111;
        end else begin
            sclk_sync_q <= {sclk_sync_q[1:0], sclk};
            copi_sync_q <= {copi_sync_q[1:0], copi};
            ncs_sync_q  <= {ncs_sync_q[1:0], ncs};
        end
    end

    assign sclk_rise_c = sclk_sync_q[1] & ~sclk_sync_q[2];
    assign ncs_fall_c  = ~ncs_sync_q[1] & ncs_sync_q[2];
    assign ncs_rise_c  = ncs_sync_q[1] & ~ncs_sync_q[2];
    assign start_c     = armed_q & ncs_fall_c;
    assign addr_c      = shift_q[FRAME_W-2:DATA_W];
    assign shift_nx_c  = {shift_q[FRAME_W-2:0], copi_sync_q[2]};

    // Frame starts are blocked after reset until ncs has been seen high, so a
    // frame cut by reset is never resumed mid-way
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_q <= 2'b00;
            armed_q  <= 1'b0;
        end else begin
            settle_q <= {settle_q[0], 1'b1};
            if (settle_q[1] && ncs_sync_q[1]) begin
                armed_q <= 1'b1;
            end
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_c || pend_q) state_d = ST_SHIFT;
            ST_SHIFT:  if (ncs_rise_c)        state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // FSM output decode
    always_comb begin
        clear_c    = 1'b0;
        shift_en_c = 1'b0;
        commit_c   = 1'b0;
        case (state_q)
            ST_IDLE:   clear_c    = start_c | pend_q;
            ST_SHIFT:  shift_en_c = sclk_rise_c;
            ST_COMMIT: commit_c   = 1'b1;
            default:   clear_c    = 1'b0;
        endcase
    end

    assign wr_en_c = commit_c && (cnt_q == CNT_FULL) && shift_q[FRAME_W-1] && (addr_c <= ADDR_MAX);
    assign err_c   = commit_c && (cnt_q != CNT_FULL);

    // Remember a new frame start that coincides with COMMIT
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            pend_q <= 1'b0;
        end else if (commit_c && start_c) begin
            pend_q <= 1'b1;
        end
    end

    // Serial capture with a bit counter that saturates one past a full frame
    always_ff @(posedge clk) begin
        if (rst || clear_c) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else if (shift_en_c) begin
            shift_q <= shift_nx_c;
            if (cnt_q != CNT_SAT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Register file update on a well-formed in-range write
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(NUM_REGS); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wr_en_c) begin
            regs_q[addr_c[2:0]] <= shift_q[DATA_W-1:0];
        end
    end

    // One-clk malformed-frame pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= err_c;
        end
    end

    assign en_reg_out_7_0  = regs_q[0];
    assign en_reg_out_15_8 = regs_q[1];
    assign en_reg_pwm_7_0  = regs_q[2];
    assign en_reg_pwm_15_8 = regs_q[3];
    assign pwm_duty_cycle  = regs_q[4];
    assign frame_err       = frame_err_q;

`ifdef SPI_READBACK_EN
    logic [DATA_W-1:0] rd_sh_q;
    logic [ADDR_W-1:0] rd_addr_c;
    logic [DATA_W-1:0] rd_data_c;
    logic              sclk_fall_c;
    logic              rd_load_c;
    logic              rd_shift_c;

    assign sclk_fall_c = ~sclk_sync_q[1] & sclk_sync_q[2];
    assign rd_addr_c   = shift_nx_c[ADDR_W-1:0];
    assign rd_data_c   = (rd_addr_c <= ADDR_MAX) ? regs_q[rd_addr_c[2:0]] : regs_q[0];
    assign rd_load_c   = shift_en_c && (cnt_q == CNT_W'(DATA_W - 1)) && !shift_nx_c[DATA_W-1];
    assign rd_shift_c  = sclk_fall_c && (cnt_q > CNT_W'(DATA_W)) && (cnt_q <= CNT_FULL);

    // Readback shifter: load after the address byte, advance on falling sclk
    always_ff @(posedge clk) begin
        if (rst || (state_q != ST_SHIFT)) begin
            rd_sh_q <= '0;
        end else if (rd_load_c) begin
            rd_sh_q <= rd_data_c;
        end else if (rd_shift_c) begin
            rd_sh_q <= {rd_sh_q[DATA_W-2:0], 1'b0};
        end
    end

    assign cipo = rd_sh_q[DATA_W-1];
`else
    assign cipo = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral: directed table, corner sequences and random frames for
// spi_peripheral, checked against a register-map model. Honours SPI_READBACK_EN.
module tb_spi_peripheral;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       sclk = 1'b0;
    logic       copi = 1'b0;
    logic       ncs = 1'b1;
    logic       cipo;
    logic [7:0] en_reg_out_7_0;
    logic [7:0] en_reg_out_15_8;
    logic [7:0] en_reg_pwm_7_0;
    logic [7:0] en_reg_pwm_15_8;
    logic [7:0] pwm_duty_cycle;
    logic       frame_err;

    spi_peripheral dut (
        .clk             (clk),
        .rst             (rst),
        .sclk            (sclk),
        .copi            (copi),
        .ncs             (ncs),
        .cipo            (cipo),
        .en_reg_out_7_0  (en_reg_out_7_0),
        .en_reg_out_15_8 (en_reg_out_15_8),
        .en_reg_pwm_7_0  (en_reg_pwm_7_0),
        .en_reg_pwm_15_8 (en_reg_pwm_15_8),
        .pwm_duty_cycle  (pwm_duty_cycle),
        .frame_err       (frame_err)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          err_seen = 0;
    int          err_wide = 0;
    logic        err_prev = 1'b0;
    logic [15:0] rd_word;
    logic [7:0]  model [5];

    // Count frame_err pulses and flag any pulse longer than one clk
    always @(negedge clk) begin
        if (frame_err === 1'b1) begin
            err_seen++;
            if (err_prev) err_wide++;
        end
        err_prev = (frame_err === 1'b1);
    end

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] regs_now();
        return {pwm_duty_cycle, en_reg_pwm_15_8, en_reg_pwm_7_0, en_reg_out_15_8, en_reg_out_7_0};
    endfunction

    function automatic logic [39:0] model_pack();
        return {model[4], model[3], model[2], model[1], model[0]};
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 5; i++) model[i] = 8'h00;
    endfunction

    // Register-map reference: returns expected frame_err pulses, and the byte a read returns
    function automatic int model_apply(input logic [31:0] val, input int n, output logic [7:0] rd_exp);
        logic [15:0] w;
        int          addr;
        rd_exp = 8'h00;
        if (n != 16) return 1;
        w    = val[15:0];
        addr = int'(w[14:8]);
        if (w[15]) begin
            if (addr <= 4) model[addr] = w[7:0];
        end else begin
            rd_exp = (addr <= 4) ? model[addr] : model[0];
        end
        return 0;
    endfunction

    task automatic begin_frame();
        @(posedge clk);
        #3 ncs = 1'b0;
        #40;
    endtask

    // Mode-0 controller: set copi, raise sclk (sampling cipo there), lower sclk
    task automatic clock_bits(input logic [31:0] val, input int n);
        for (int i = n - 1; i >= 0; i--) begin
            int k;
            k = n - 1 - i;
            copi = val[i];
            #40 sclk = 1'b1;
            if (k < 16) rd_word[15-k] = cipo;
            #40 sclk = 1'b0;
        end
    endtask

    task automatic end_frame();
        #40;
        @(posedge clk);
        #3 ncs = 1'b1;
    endtask

    // Full frame; registers sampled 4 clk after ncs rises, pulses counted afterwards
    task automatic run_frame(input logic [31:0] val, input int n, output logic [39:0] regs4, output int errs);
        int e0;
        e0      = err_seen;
        rd_word = 16'h0000;
        begin_frame();
        clock_bits(val, n);
        end_frame();
        repeat (4) @(posedge clk);
        #1 regs4 = regs_now();
        repeat (6) @(posedge clk);
        #1 errs = err_seen - e0;
    endtask

    typedef struct {
        logic [31:0] bits;
        int          n;
        logic [39:0] exp_regs;
        int          exp_err;
    } vec_t;

    vec_t        vecs [7];
    logic [39:0] r4;
    int          errs;
    int          e0;
    logic [7:0]  rd_exp;
    int          dummy;

    initial begin
        vecs[0] = '{32'h0000_8055, 16, 40'h00_00_00_00_55, 0};
        vecs[1] = '{32'h0000_84FF, 16, 40'hFF_00_00_00_55, 0};
        vecs[2] = '{32'h0000_8380, 16, 40'hFF_80_00_00_55, 0};
        vecs[3] = '{32'h0000_8A12, 16, 40'hFF_80_00_00_55, 0};
        vecs[4] = '{32'h0000_4155, 15, 40'hFF_80_00_00_55, 1};
        vecs[5] = '{32'h0001_0554, 17, 40'hFF_80_00_00_55, 1};
        vecs[6] = '{32'h0000_0400, 16, 40'hFF_80_00_00_55, 0};

        model_reset();
        repeat (3) @(posedge clk);
        #3 rst = 1'b0;
        @(negedge clk);
        check("reset_regs", regs_now(), 40'h0);
        check("reset_frame_err", {39'h0, frame_err}, 40'h0);
        check("reset_cipo", {39'h0, cipo}, 40'h0);
        repeat (4) @(posedge clk);

        // Directed table: writes, out-of-range address, short and long frames, read
        for (int v = 0; v < 7; v++) begin
            dummy = model_apply(vecs[v].bits, vecs[v].n, rd_exp);
            run_frame(vecs[v].bits, vecs[v].n, r4, errs);
            check($sformatf("vec%0d_regs", v), r4, vecs[v].exp_regs);
            check($sformatf("vec%0d_err", v), 40'(errs), 40'(vecs[v].exp_err));
            check($sformatf("vec%0d_cipo_idle", v), {39'h0, cipo}, 40'h0);
        end

        // Write then read back address 0x04
        dummy = model_apply(32'h84C3, 16, rd_exp);
        run_frame(32'h84C3, 16, r4, errs);
        check("rb_write_reg4", 40'(r4[39:32]), 40'hC3);
        dummy = model_apply(32'h0400, 16, rd_exp);
        run_frame(32'h0400, 16, r4, errs);
`ifdef SPI_READBACK_EN
        check("rb_cipo_bits", 40'(rd_word[7:0]), 40'hC3);
`else
        check("rb_cipo_zero", 40'(rd_word), 40'h0);
`endif
        check("rb_regs_kept", r4, model_pack());
        check("rb_err", 40'(errs), 40'h0);

        // ncs falls again in the COMMIT clk of the previous frame
        e0 = err_seen;
        dummy = model_apply(32'h8111, 16, rd_exp);
        dummy = model_apply(32'h8222, 16, rd_exp);
        begin_frame();
        clock_bits(32'h8111, 16);
        end_frame();
        @(posedge clk);
        #3 ncs = 1'b0;
        #40;
        clock_bits(32'h8222, 16);
        end_frame();
        repeat (4) @(posedge clk);
        #1 check("b2b_regs", regs_now(), model_pack());
        repeat (6) @(posedge clk);
        #1 check("b2b_err", 40'(err_seen - e0), 40'h0);

        // Reset during bit 9 of a write; frame must be abandoned until ncs re-falls
        e0 = err_seen;
        begin_frame();
        clock_bits(32'h0000_8133 >> 7, 9);
        @(posedge clk);
        #3 rst = 1'b1;
        repeat (2) @(posedge clk);
        #3 rst = 1'b0;
        model_reset();
        clock_bits(32'h0000_0033, 7);
        end_frame();
        repeat (10) @(posedge clk);
        #1 check("rstmid_regs", regs_now(), 40'h0);
        check("rstmid_err", 40'(err_seen - e0), 40'h0);
        dummy = model_apply(32'h8133, 16, rd_exp);
        run_frame(32'h8133, 16, r4, errs);
        check("rstmid_rearm", r4, model_pack());

        // Random frames, with stray sclk activity while deselected
        for (int t = 0; t < 40; t++) begin
            logic [15:0] w;
            logic [31:0] val;
            int          n;
            int          exp_err;
            int          kind;
            kind = int'($urandom_range(0, 9));
            w    = {1'($urandom_range(0, 1)), 7'($urandom_range(0, 7)), 8'($urandom)};
            if (kind == 0) begin
                n = 15; val = 32'(w >> 1);
            end else if (kind == 1) begin
                n = 17; val = {15'h0, w, 1'($urandom_range(0, 1))};
            end else begin
                n = 16; val = {16'h0, w};
            end
            if ($urandom_range(0, 2) == 0) begin
                for (int s = 0; s < 3; s++) begin
                    copi = 1'($urandom_range(0, 1));
                    #40 sclk = 1'b1;
                    #40 sclk = 1'b0;
                end
            end
            exp_err = model_apply(val, n, rd_exp);
            run_frame(val, n, r4, errs);
            check($sformatf("rnd%0d_regs", t), r4, model_pack());
            check($sformatf("rnd%0d_err", t), 40'(errs), 40'(exp_err));
            check($sformatf("rnd%0d_cipo_idle", t), {39'h0, cipo}, 40'h0);
            if (n == 16 && !w[15]) begin
`ifdef SPI_READBACK_EN
                check($sformatf("rnd%0d_read", t), 40'(rd_word[7:0]), 40'(rd_exp));
`else
                check($sformatf("rnd%0d_read", t), 40'(rd_word), 40'h0);
`endif
            end
        end

        check("err_pulse_width", 40'(err_wide), 40'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
